md_issue_ctrl: RTL

//  EX-stage issue/interlock controller directly upstream of the multiply/divide unit.

---
 rtl/md_issue_ctrl.sv | 102 ++++++++++
 1 files changed

// File: rtl/md_issue_ctrl.sv
// EX-stage issue/interlock controller in front of the multiply/divide unit.
// Optional stall-cycle performance counter enabled by defining MD_PERF_CNT_EN.
module md_issue_ctrl #(
   parameter int TIMEOUT = 20,
   parameter int CNT_W   = 5
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        ex_valid,
   input  logic [3:0]  ex_op,
   input  logic        ex_flush,
   input  logic        md_busy,
   output logic        md_start,
   output logic        md_hilo_we,
   output logic [3:0]  md_op,
   output logic        stall,
   output logic        md_timeout,
   output logic [31:0] perf_stall_cnt
);

   typedef enum logic {S_IDLE, S_RUN} state_t;

   localparam logic [CNT_W-1:0] LP_LAST = CNT_W'(TIMEOUT - 1);

   state_t           r_state, w_state_nxt;
   logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
   logic             r_seen_busy, w_seen_nxt;
   logic             r_timeout, w_timeout_nxt;

   logic w_is_arith, w_is_mt, w_is_mf, w_is_md, w_blocked;

   assign w_is_arith = ex_valid && (ex_op >= 4'd1) && (ex_op <= 4'd4);
   assign w_is_mt    = ex_valid && (ex_op == 4'd5 || ex_op == 4'd6);
   assign w_is_mf    = ex_valid && (ex_op == 4'd7 || ex_op == 4'd8);
   assign w_is_md    = w_is_arith || w_is_mt || w_is_mf;

   // The cycle right after a start counts as blocked even before Busy rises.
   assign w_blocked  = (r_state == S_RUN) || md_busy;

   assign stall      = w_is_md && w_blocked && !ex_flush;
   assign md_start   = w_is_arith && !w_blocked && !ex_flush;
   assign md_hilo_we = w_is_mt && !w_blocked && !ex_flush;
   assign md_op      = (md_start || md_hilo_we) ? ex_op : 4'd0;
   assign md_timeout = r_timeout;

   always_comb begin
      w_state_nxt   = r_state;
      w_cnt_nxt     = r_cnt;
      w_seen_nxt    = r_seen_busy;
      w_timeout_nxt = r_timeout;
      unique case (r_state)
         S_IDLE: begin
            if (md_start) begin
               w_state_nxt = S_RUN;
               w_cnt_nxt   = '0;
               w_seen_nxt  = 1'b0;
            end
         end
         S_RUN: begin
            w_cnt_nxt  = r_cnt + 1'b1;
            w_seen_nxt = r_seen_busy || md_busy;
            if (r_seen_busy && !md_busy) begin
               w_state_nxt = S_IDLE;
            end else if (r_cnt == LP_LAST) begin
               w_state_nxt   = S_IDLE;
               w_timeout_nxt = 1'b1;
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= S_IDLE;
         r_cnt       <= '0;
         r_seen_busy <= 1'b0;
         r_timeout   <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_cnt       <= w_cnt_nxt;
         r_seen_busy <= w_seen_nxt;
         r_timeout   <= w_timeout_nxt;
      end
   end

`ifdef MD_PERF_CNT_EN
   logic [31:0] r_perf;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_perf <= 32'h0;
      end else if (stall) begin
         r_perf <= r_perf + 32'd1;
      end
   end

   assign perf_stall_cnt = r_perf;
`else
   assign perf_stall_cnt = 32'h0;
`endif

endmodule
